// File: rtl/ip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : ip_pkg                                                    |
// | Purpose   : Shared constants and enumerations for the IPv4 receive    |
// |             path (header parser, downstream demux).                   |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ip_pkg;

   localparam int         IP_HDR_BYTES = 20;
   localparam logic [3:0] IP_VERSION   = 4'd4;
   localparam logic [3:0] IP_IHL_MIN   = 4'd5;

   typedef enum logic [2:0] {
      NONE     = 3'd0,
      BAD_VER  = 3'd1,
      BAD_IHL  = 3'd2,
      BAD_LEN  = 3'd3,
      BAD_CSUM = 3'd4,
      FRAG     = 3'd5,
      RUNT     = 3'd6,
      TRUNC    = 3'd7
   } drop_t;

   typedef enum logic [2:0] {
      HEADER   = 3'd0,
      HDR_OUT  = 3'd1,
      PAYLOAD  = 3'd2,
      DISCARD  = 3'd3,
      DROP     = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/ip_header_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : ip_header_parser_if                                       |
// | Purpose   : Bundles the byte input stream, header metadata channel,   |
// |             payload output stream and drop indication of the parser.  |
// | Modports  : master - upstream source / downstream sinks (environment) |
// |             slave  - the header parser itself                         |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface ip_header_parser_if;
   import ip_pkg::*;

   logic        axis_i_tready;
   logic        axis_i_tvalid;
   logic        axis_i_tlast;
   logic [7:0]  axis_i_tdata;

   logic        hdr_tready;
   logic        hdr_tvalid;
   logic [31:0] hdr_src_ip;
   logic [31:0] hdr_dest_ip;
   logic [7:0]  hdr_protocol;
   logic [15:0] hdr_payload_len;

   logic        axis_o_tready;
   logic        axis_o_tvalid;
   logic        axis_o_tlast;
   logic [7:0]  axis_o_tdata;

   logic        drop_pulse;
   drop_t       drop_reason;

   modport master (
      output axis_i_tvalid, axis_i_tlast, axis_i_tdata, hdr_tready, axis_o_tready,
      input  axis_i_tready, hdr_tvalid, hdr_src_ip, hdr_dest_ip, hdr_protocol,
             hdr_payload_len, axis_o_tvalid, axis_o_tlast, axis_o_tdata,
             drop_pulse, drop_reason
   );

   modport slave (
      input  axis_i_tvalid, axis_i_tlast, axis_i_tdata, hdr_tready, axis_o_tready,
      output axis_i_tready, hdr_tvalid, hdr_src_ip, hdr_dest_ip, hdr_protocol,
             hdr_payload_len, axis_o_tvalid, axis_o_tlast, axis_o_tdata,
             drop_pulse, drop_reason
   );

endinterface
`default_nettype wire

// File: rtl/ones_complement_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : ones_complement_accum                                     |
// | Purpose   : Byte-serial 16-bit ones-complement sum (Internet checksum)|
// |             Bytes pair up MSB-first into 16-bit words.                |
// | Ports     : clk, sreset     - clock, synchronous active-high reset    |
// |             clear           - restart the sum on the next cycle       |
// |             byte_valid      - byte_in is consumed this cycle          |
// |             byte_in[7:0]    - data byte                               |
// |             sum[15:0]       - running sum including the current byte  |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ones_complement_accum (
   input  logic        clk,
   input  logic        sreset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [15:0] sum
);

   logic        odd;        // next byte is the low half of a word
   logic [7:0]  hi_byte;
   logic [15:0] acc;
   logic [16:0] raw;
   logic [15:0] folded;

   // End-around carry: one fold is enough since FFFF+FFFF folds to FFFF.
   // sum looks through the current byte so a caller can test the final
   // word in the same cycle it arrives.
   always_comb begin
      raw    = {1'b0, acc} + {1'b0, hi_byte, byte_in};
      folded = raw[15:0] + {15'd0, raw[16]};
      sum    = (byte_valid && odd) ? folded : acc;
   end

   always_ff @(posedge clk) begin
      if (sreset || clear) begin
         odd     <= 1'b0;
         hi_byte <= 8'd0;
         acc     <= 16'd0;
      end else if (byte_valid) begin
         if (odd) begin
            acc <= folded;
         end else begin
            hi_byte <= byte_in;
         end
         odd <= !odd;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ip_header_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : ip_header_parser                                          |
// | Purpose   : Strips and validates a fixed 20-byte IPv4 header from a   |
// |             byte-wide stream, emits the header fields as one metadata |
// |             beat, then forwards exactly payload_len payload bytes.    |
// |             Bad headers are dropped without buffering.                |
// | Ports     : clk, sreset - clock, synchronous active-high reset        |
// |             bus (slave) - input stream, metadata, payload stream and  |
// |                           drop_pulse/drop_reason                      |
// | Params    : CHECK_CHECKSUM - drop on header checksum mismatch         |
// |             DROP_FRAGMENTS - drop when MF set or offset non-zero      |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ip_header_parser #(
   parameter bit CHECK_CHECKSUM = 1'b1,
   parameter bit DROP_FRAGMENTS = 1'b1
) (
   input  logic          clk,
   input  logic          sreset,
   ip_header_parser_if.slave bus
);
   import ip_pkg::*;

   localparam logic [4:0] LAST_HDR_BYTE = 5'(IP_HDR_BYTES - 1);

   state_t      state, state_next;
   logic [4:0]  byte_cnt;
   logic [15:0] rem;
   logic [7:0]  ver_ihl;
   logic [15:0] total_len;
   logic        mf_flag;
   logic [12:0] frag_off;
   logic [7:0]  protocol;
   logic [31:0] src_ip;
   logic [31:0] dest_ip;
   logic [15:0] payload_len;
   logic        tlast_seen;   // frame ended on the last header byte

   logic        in_ready;
   logic        in_fire;
   logic        hdr_byte;
   logic        hdr_done;
   logic [15:0] csum;
   drop_t       verdict;
   logic        out_valid, out_last, hdr_valid, pulse;
   drop_t       reason;

   always_comb begin
      in_ready = 1'b0;
      case (state)
         HEADER, DISCARD, DROP: in_ready = 1'b1;
         PAYLOAD:               in_ready = bus.axis_o_tready;
         default:               in_ready = 1'b0;
      endcase
   end

   assign in_fire  = bus.axis_i_tvalid && in_ready;
   assign hdr_byte = (state == HEADER) && in_fire;
   // The header window closes on byte 19 or on an early tlast (runt).
   assign hdr_done = hdr_byte && ((byte_cnt == LAST_HDR_BYTE) || bus.axis_i_tlast);

   ones_complement_accum u_csum (
      .clk        (clk),
      .sreset     (sreset),
      .clear      (hdr_done),
      .byte_valid (hdr_byte),
      .byte_in    (bus.axis_i_tdata),
      .sum        (csum)
   );

   // Evaluated on byte 19; every field it reads was captured earlier
   // except the checksum, which the accumulator presents combinationally.
   always_comb begin
      verdict = NONE;
      if (ver_ihl[7:4] != IP_VERSION)                          verdict = BAD_VER;
      else if (ver_ihl[3:0] != IP_IHL_MIN)                     verdict = BAD_IHL;
      else if (total_len < 16'(IP_HDR_BYTES))                  verdict = BAD_LEN;
      else if (CHECK_CHECKSUM && (csum != 16'hFFFF))           verdict = BAD_CSUM;
      else if (DROP_FRAGMENTS && (mf_flag || frag_off != '0))  verdict = FRAG;
   end

   always_comb begin
      state_next = state;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      hdr_valid  = 1'b0;
      pulse      = 1'b0;
      reason     = NONE;
      case (state)
         HEADER: begin
            if (in_fire && byte_cnt == LAST_HDR_BYTE) begin
               if (verdict == NONE) begin
                  state_next = HDR_OUT;
               end else begin
                  pulse      = 1'b1;
                  reason     = verdict;
                  state_next = bus.axis_i_tlast ? HEADER : DROP;
               end
            end else if (in_fire && bus.axis_i_tlast) begin
               pulse  = 1'b1;
               reason = RUNT;
            end
         end
         HDR_OUT: begin
            hdr_valid = 1'b1;
            if (bus.hdr_tready) begin
               if (payload_len == 16'd0) begin
                  state_next = tlast_seen ? HEADER : DISCARD;
               end else if (tlast_seen) begin
                  // Frame ended exactly at the header: nothing will follow.
                  pulse      = 1'b1;
                  reason     = TRUNC;
                  state_next = HEADER;
               end else begin
                  state_next = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            out_valid = bus.axis_i_tvalid;
            out_last  = (rem == 16'd1) || bus.axis_i_tlast;
            if (in_fire) begin
               if (rem == 16'd1) begin
                  state_next = bus.axis_i_tlast ? HEADER : DISCARD;
               end else if (bus.axis_i_tlast) begin
                  pulse      = 1'b1;
                  reason     = TRUNC;
                  state_next = HEADER;
               end
            end
         end
         DISCARD, DROP: begin
            if (in_fire && bus.axis_i_tlast) state_next = HEADER;
         end
         default: state_next = HEADER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sreset) begin
         state       <= HEADER;
         byte_cnt    <= 5'd0;
         rem         <= 16'd0;
         ver_ihl     <= 8'd0;
         total_len   <= 16'd0;
         mf_flag     <= 1'b0;
         frag_off    <= 13'd0;
         protocol    <= 8'd0;
         src_ip      <= 32'd0;
         dest_ip     <= 32'd0;
         payload_len <= 16'd0;
         tlast_seen  <= 1'b0;
      end else begin
         state <= state_next;
         if (hdr_byte) begin
            byte_cnt <= hdr_done ? 5'd0 : byte_cnt + 5'd1;
            case (byte_cnt)
               5'd0:  ver_ihl          <= bus.axis_i_tdata;
               5'd2:  total_len[15:8]  <= bus.axis_i_tdata;
               5'd3:  total_len[7:0]   <= bus.axis_i_tdata;
               5'd6: begin
                  mf_flag        <= bus.axis_i_tdata[5];
                  frag_off[12:8] <= bus.axis_i_tdata[4:0];
               end
               5'd7:  frag_off[7:0]    <= bus.axis_i_tdata;
               5'd9:  protocol         <= bus.axis_i_tdata;
               5'd12, 5'd13, 5'd14, 5'd15:
                      src_ip  <= {src_ip[23:0], bus.axis_i_tdata};
               5'd16, 5'd17, 5'd18, 5'd19:
                      dest_ip <= {dest_ip[23:0], bus.axis_i_tdata};
               default: ;
            endcase
            if (byte_cnt == LAST_HDR_BYTE) begin
               payload_len <= total_len - 16'd20;
               tlast_seen  <= bus.axis_i_tlast;
            end
         end
         if (state == HDR_OUT && bus.hdr_tready) begin
            rem <= payload_len;
         end else if (state == PAYLOAD && in_fire) begin
            rem <= rem - 16'd1;
         end
      end
   end

   assign bus.axis_i_tready   = in_ready;
   assign bus.axis_o_tvalid   = out_valid;
   assign bus.axis_o_tlast    = out_last;
   assign bus.axis_o_tdata    = bus.axis_i_tdata;
   assign bus.hdr_tvalid      = hdr_valid;
   assign bus.hdr_src_ip      = src_ip;
   assign bus.hdr_dest_ip     = dest_ip;
   assign bus.hdr_protocol    = protocol;
   assign bus.hdr_payload_len = payload_len;
   assign bus.drop_pulse      = pulse;
   assign bus.drop_reason     = reason;

endmodule
`default_nettype wire

// File: tb/tb_ip_header_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_ip_header_parser                                       |
// | Purpose   : Self-checking bench for ip_header_parser. Expected header |
// |             records, payload beats and drop reasons are queued when a |
// |             frame is driven and compared as the DUT produces them.    |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ip_header_parser;
   import ip_pkg::*;

   typedef logic [7:0] bq_t [$];

   logic clk = 1'b0;
   logic sreset;
   always #5 clk = ~clk;

   ip_header_parser_if bus();

   ip_header_parser #(
      .CHECK_CHECKSUM (1'b1),
      .DROP_FRAGMENTS (1'b1)
   ) dut (
      .clk    (clk),
      .sreset (sreset),
      .bus    (bus)
   );

   logic [87:0] exp_hdr [$];   // {src, dst, proto, payload_len}
   logic [8:0]  exp_out [$];   // {tlast, data}
   drop_t       exp_drop [$];

   int          checks = 0;
   int          errors = 0;
   bit          bp = 1'b0;
   bit          hdr_hold = 1'b0;
   logic [87:0] held = '0;

   localparam logic [159:0] SPEC_HDR = 160'h4500001CA86C400040110F11C0A80101C0A80102;

   function automatic logic [87:0] hdr_now();
      return {bus.hdr_src_ip, bus.hdr_dest_ip, bus.hdr_protocol, bus.hdr_payload_len};
   endfunction

   task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: set sink readiness, sample away from the edge, score.
   task automatic step(output bit accepted);
      logic [8:0] eo;
      drop_t      ed;
      if (bp) begin
         bus.hdr_tready    = 1'($urandom_range(0, 1));
         bus.axis_o_tready = 1'($urandom_range(0, 1));
      end else begin
         bus.hdr_tready    = 1'b1;
         bus.axis_o_tready = 1'b1;
      end
      #1;
      if (bus.hdr_tvalid) begin
         if (hdr_hold) check("hdr_stable", hdr_now(), held);
         if (bus.hdr_tready) begin
            checks++;
            assert (exp_hdr.size() > 0)
            else begin
               errors++;
               $error("FAIL unexpected_hdr: observed %0h expected none", hdr_now());
            end
            if (exp_hdr.size() > 0) check("hdr_fields", hdr_now(), exp_hdr.pop_front());
         end
      end
      hdr_hold = bus.hdr_tvalid && !bus.hdr_tready;
      held     = hdr_now();
      if (bus.axis_o_tvalid && bus.axis_o_tready) begin
         checks++;
         assert (exp_out.size() > 0)
         else begin
            errors++;
            $error("FAIL unexpected_beat: observed %0h expected none",
                   {bus.axis_o_tlast, bus.axis_o_tdata});
         end
         if (exp_out.size() > 0) begin
            eo = exp_out.pop_front();
            check("payload_beat", 88'({bus.axis_o_tlast, bus.axis_o_tdata}), 88'(eo));
         end
      end
      if (bus.drop_pulse) begin
         checks++;
         assert (exp_drop.size() > 0)
         else begin
            errors++;
            $error("FAIL unexpected_drop: observed %0d expected none", bus.drop_reason);
         end
         if (exp_drop.size() > 0) begin
            ed = exp_drop.pop_front();
            check("drop_reason", 88'(bus.drop_reason), 88'(ed));
         end
      end
      accepted = bus.axis_i_tvalid && bus.axis_i_tready;
      @(negedge clk);
   endtask

   task automatic drive_frame(input bq_t f);
      bit acc;
      int waited;
      foreach (f[i]) begin
         bus.axis_i_tvalid = 1'b1;
         bus.axis_i_tdata  = f[i];
         bus.axis_i_tlast  = (i == f.size() - 1);
         acc    = 1'b0;
         waited = 0;
         while (!acc) begin
            step(acc);
            waited++;
            if (!acc && waited > 500) begin
               checks++;
               errors++;
               $display("FAIL input_stall: observed no accept in %0d cycles, required accept", waited);
               $display("Result: errors=%0d of %0d checks", errors, checks);
               $fatal(1, "input stream stalled");
            end
         end
      end
      bus.axis_i_tvalid = 1'b0;
      bus.axis_i_tlast  = 1'b0;
   endtask

   // Reference: whole-frame parse, independent of cycle timing.
   task automatic expect_frame(input bq_t f);
      int          n, avail, k;
      logic [15:0] tl, plen;
      bit   [31:0] s;
      drop_t       v;
      n = f.size();
      if (n < 20) begin
         exp_drop.push_back(RUNT);
         return;
      end
      tl = {f[2], f[3]};
      s  = 0;
      for (int i = 0; i < 20; i += 2) s += {16'd0, f[i], f[i+1]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      v = NONE;
      if (f[0][7:4] != 4'd4)                          v = BAD_VER;
      else if (f[0][3:0] != 4'd5)                     v = BAD_IHL;
      else if (tl < 16'd20)                           v = BAD_LEN;
      else if (s[15:0] != 16'hFFFF)                   v = BAD_CSUM;
      else if (f[6][5] || {f[6][4:0], f[7]} != 13'd0) v = FRAG;
      if (v != NONE) begin
         exp_drop.push_back(v);
         return;
      end
      plen = tl - 16'd20;
      exp_hdr.push_back({f[12], f[13], f[14], f[15], f[16], f[17], f[18], f[19], f[9], plen});
      avail = n - 20;
      if (plen == 16'd0) return;
      if (avail == 0) begin
         exp_drop.push_back(TRUNC);
         return;
      end
      k = (avail < int'(plen)) ? avail : int'(plen);
      for (int i = 0; i < k; i++) exp_out.push_back({(i == k - 1), f[20 + i]});
      if (avail < int'(plen)) exp_drop.push_back(TRUNC);
   endtask

   task automatic send(input bq_t f);
      expect_frame(f);
      drive_frame(f);
   endtask

   task automatic build(output bq_t f, input logic [7:0] vi, input logic [15:0] tl,
                        input logic [15:0] fl, input logic [7:0] proto,
                        input logic [31:0] src, input logic [31:0] dst,
                        input int extra, input bit bad_cs);
      logic [159:0] h;
      bit   [31:0]  s;
      logic [15:0]  cs;
      h = {vi, 8'h00, tl, 16'($urandom), fl, 8'h40, proto, 16'h0000, src, dst};
      s = 0;
      for (int i = 0; i < 10; i++) s += {16'd0, h[159 - 16*i -: 16]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      cs = ~s[15:0];
      if (bad_cs) cs = cs ^ 16'h0001;
      h[79:64] = cs;
      f = {};
      for (int i = 0; i < 20; i++) f.push_back(h[159 - 8*i -: 8]);
      for (int i = 0; i < extra; i++) f.push_back(8'($urandom));
   endtask

   task automatic spec_frame(output bq_t f, input int npay, input int npad);
      f = {};
      for (int i = 0; i < 20; i++) f.push_back(SPEC_HDR[159 - 8*i -: 8]);
      for (int i = 0; i < npay; i++) f.push_back(8'(i + 1));
      for (int i = 0; i < npad; i++) f.push_back(8'hEE);
   endtask

   task automatic push_spec_expect();
      exp_hdr.push_back({32'hC0A80101, 32'hC0A80102, 8'h11, 16'd8});
      for (int i = 0; i < 8; i++) exp_out.push_back({(i == 7), 8'(i + 1)});
   endtask

   task automatic drain(input string tag);
      bit acc;
      int n;
      n = 0;
      bus.axis_i_tvalid = 1'b0;
      bus.axis_i_tlast  = 1'b0;
      while ((exp_hdr.size() + exp_out.size() + exp_drop.size()) > 0 && n < 2000) begin
         step(acc);
         n++;
      end
      repeat (4) step(acc);
      check({tag, "_hdr_left"},  88'(exp_hdr.size()),  88'd0);
      check({tag, "_beat_left"}, 88'(exp_out.size()),  88'd0);
      check({tag, "_drop_left"}, 88'(exp_drop.size()), 88'd0);
   endtask

   initial begin
      bq_t         f;
      int          kind, npay, rl;
      logic [31:0] src, dst;
      logic [7:0]  proto;

      sreset            = 1'b1;
      bus.axis_i_tvalid = 1'b0;
      bus.axis_i_tlast  = 1'b0;
      bus.axis_i_tdata  = 8'd0;
      bus.hdr_tready    = 1'b1;
      bus.axis_o_tready = 1'b1;
      repeat (3) @(negedge clk);
      sreset = 1'b0;
      #1;
      check("rst_hdr_tvalid",  88'(bus.hdr_tvalid),    88'd0);
      check("rst_o_tvalid",    88'(bus.axis_o_tvalid), 88'd0);
      check("rst_drop_pulse",  88'(bus.drop_pulse),    88'd0);
      check("rst_i_tready",    88'(bus.axis_i_tready), 88'd1);
      check("rst_hdr_fields",  hdr_now(),              88'd0);
      @(negedge clk);

      // Reference packet from the datasheet example.
      spec_frame(f, 8, 0);
      push_spec_expect();
      drive_frame(f);
      drain("good");

      // Corrupted checksum, then the good packet must still parse.
      spec_frame(f, 8, 0);
      f[11] = 8'h12;
      exp_drop.push_back(BAD_CSUM);
      drive_frame(f);
      spec_frame(f, 8, 0);
      push_spec_expect();
      drive_frame(f);
      drain("csum");

      // Ethernet padding after the payload is absorbed silently.
      spec_frame(f, 8, 18);
      push_spec_expect();
      drive_frame(f);
      drain("pad");

      // Runt frame.
      spec_frame(f, 0, 0);
      while (f.size() > 12) void'(f.pop_back());
      exp_drop.push_back(RUNT);
      drive_frame(f);
      drain("runt");

      // Truncated: total_len 28 but only 3 payload bytes.
      build(f, 8'h45, 16'd28, 16'h4000, 8'h11, 32'h0A000001, 32'h0A000002, 3, 1'b0);
      send(f);
      drain("trunc");

      // Zero-length payload, with and without padding.
      build(f, 8'h45, 16'h0014, 16'h4000, 8'h01, 32'h01020304, 32'h05060708, 0, 1'b0);
      send(f);
      build(f, 8'h45, 16'h0014, 16'h4000, 8'h01, 32'h01020304, 32'h05060708, 6, 1'b0);
      send(f);
      drain("zero_len");

      // Header-field faults.
      build(f, 8'h46, 16'd24, 16'h4000, 8'h11, 32'h0A000001, 32'h0A000002, 4, 1'b0);
      send(f);
      build(f, 8'h45, 16'd24, 16'h2000, 8'h11, 32'h0A000001, 32'h0A000002, 4, 1'b0);
      send(f);
      build(f, 8'h45, 16'd24, 16'h0001, 8'h11, 32'h0A000001, 32'h0A000002, 4, 1'b0);
      send(f);
      build(f, 8'h45, 16'h0010, 16'h4000, 8'h11, 32'h0A000001, 32'h0A000002, 4, 1'b0);
      send(f);
      build(f, 8'h55, 16'd24, 16'h4000, 8'h11, 32'h0A000001, 32'h0A000002, 4, 1'b0);
      send(f);
      drain("fields");

      // Mixed random traffic with 50% backpressure on both sinks.
      bp = 1'b1;
      for (int p = 0; p < 1000; p++) begin
         kind  = $urandom_range(0, 9);
         npay  = $urandom_range(0, 12);
         src   = $urandom;
         dst   = $urandom;
         proto = 8'($urandom);
         case (kind)
            0: begin
               build(f, 8'h45, 16'(20 + npay), 16'h4000, proto, src, dst, npay, 1'b0);
               rl = $urandom_range(1, 19);
               while (f.size() > rl) void'(f.pop_back());
            end
            1: build(f, 8'h45, 16'(20 + npay), 16'h4000, proto, src, dst, npay, 1'b1);
            2: build(f, 8'h45, 16'(24 + npay), 16'h4000, proto, src, dst, npay + 1, 1'b0);
            3: build(f, 8'h45, 16'd20, 16'h4000, proto, src, dst, $urandom_range(0, 6), 1'b0);
            default:
               build(f, 8'h45, 16'(20 + npay), 16'h4000, proto, src, dst,
                     npay + $urandom_range(0, 4), 1'b0);
         endcase
         send(f);
      end
      drain("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
